// File: rtl/adder_pkg.sv
// adder_pkg: shared state encoding and op constants for multi_cycle_adder
package adder_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/chunk_add.sv
// chunk_add: combinational W-bit adder slice, also reporting the carry into its top bit
module chunk_add #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] sum,
    output logic         co,
    output logic         c_msb
);
    assign {co, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    // the sum's top bit is a^b^carry_in, so the carry into it falls out by xor
    assign c_msb = a[W-1] ^ b[W-1] ^ sum[W-1];
endmodule

// File: rtl/multi_cycle_adder.sv
// multi_cycle_adder: WIDTH-bit add/subtract computed CHUNK bits per clock, LSB slice first
module multi_cycle_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] SL_MASK = WIDTH'({CHUNK{1'b1}});
    generate
        if (CHUNK < 1 || WIDTH % CHUNK != 0) begin : g_bad_params
            $error("multi_cycle_adder: WIDTH must be a nonzero multiple of CHUNK");
        end
    endgenerate
    state_t state, state_nx;
    logic [WIDTH-1:0] a_r, b_r, acc, acc_nx;
    logic [KW-1:0] k;
    logic [31:0] off;
    logic [CHUNK-1:0] sl_sum;
    logic carry, sl_co, sl_cmsb, last, accept;
    assign busy   = state == RUN;
    assign done   = state == DONE;
    assign last   = k == KLAST;
    assign accept = !busy && start;
    assign off    = CHUNK * 32'(k);
    // one slice adder shared by every slice through the shift-based mux
    chunk_add #(.W(CHUNK)) u_slice (
        .a    (CHUNK'(a_r >> off)),
        .b    (CHUNK'(b_r >> off)),
        .ci   (carry),
        .sum  (sl_sum),
        .co   (sl_co),
        .c_msb(sl_cmsb)
    );
    assign acc_nx = (acc & ~(SL_MASK << off)) | (WIDTH'(sl_sum) << off);
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = busy ? (last ? DONE : RUN) : (start ? RUN : IDLE);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            k     <= '0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_r   <= x;
            b_r   <= sub == OP_SUB ? ~y : y;
            carry <= sub == OP_SUB ? 1'b1 : cin;
            k     <= '0;
        end else if (busy) begin
            acc   <= acc_nx;
            carry <= sl_co;
            k     <= k + 1'b1;
            if (last) begin
                s    <= acc_nx;
                cout <= sl_co;
                ovf  <= sl_cmsb ^ sl_co;
            end
        end
    end
endmodule

// File: tb/tb_multi_cycle_adder.sv
// tb_multi_cycle_adder: directed handshake/reset checks plus randomized parameter sweep against an arithmetic model
module tb_multi_cycle_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int n_cmp = 0;
    int n_bad = 0;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // integer arithmetic reference: modular result, unsigned carry, signed range overflow
    function automatic void model(input int w, input longint xv, input longint yv, input bit sb, input bit ci,
                                  output longint sv, output bit co, output bit ov);
        longint m, u, sx, sy, r;
        m  = longint'(1) <<< w;
        u  = sb ? xv + (m - yv) : xv + yv + longint'(ci);
        sv = u % m;
        co = u >= m;
        sx = xv >= m / 2 ? xv - m : xv;
        sy = yv >= m / 2 ? yv - m : yv;
        r  = sb ? sx - sy : sx + sy + longint'(ci);
        ov = r < -(m / 2) || r >= m / 2;
    endfunction
    logic rst, start, sub, cin, busy, done, cout, ovf;
    logic [15:0] x, y, s;
    multi_cycle_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin), .x(x), .y(y),
        .busy(busy), .done(done), .s(s), .cout(cout), .ovf(ovf)
    );
    task automatic op(input string tag, input logic [15:0] xv, input logic [15:0] yv, input logic sb, input logic ci);
        longint es;
        bit eco, eov;
        int lat;
        model(16, longint'(xv), longint'(yv), sb, ci, es, eco, eov);
        start = 1'b1; x = xv; y = yv; sub = sb; cin = ci;
        @(posedge clk); #1;
        start = 1'b0; x = 16'($urandom); y = 16'($urandom); sub = ~sb; cin = ~ci;
        chk({tag, "_busy"}, busy, 1);
        lat = 0;
        while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
        chk({tag, "_lat"}, lat, 4);
        chk({tag, "_s"}, s, es);
        chk({tag, "_cout"}, cout, eco);
        chk({tag, "_ovf"}, ovf, eov);
    endtask
    for (genvar g = 0; g < 4; g++) begin : sw
        localparam int W = g == 3 ? 32 : 16;
        localparam int C = g == 0 ? 1 : g == 1 ? 4 : g == 2 ? 16 : 8;
        logic rs, st, sb, ci, bz, dn, co, ov;
        logic [W-1:0] xa, yb, sm;
        bit fin = 1'b0;
        multi_cycle_adder #(.WIDTH(W), .CHUNK(C)) u (
            .clk(clk), .rst(rs), .start(st), .sub(sb), .cin(ci), .x(xa), .y(yb),
            .busy(bz), .done(dn), .s(sm), .cout(co), .ovf(ov)
        );
        initial begin
            longint es;
            bit eco, eov;
            int lat;
            logic [63:0] r1, r2;
            rs = 1'b1; st = 1'b0; sb = 1'b0; ci = 1'b0; xa = '0; yb = '0;
            repeat (2) @(posedge clk);
            #1 rs = 1'b0;
            for (int n = 0; n < 1000; n++) begin
                r1 = {$urandom, $urandom};
                r2 = {$urandom, $urandom};
                if (n % 7 == 0) r1 = '1;
                if (n % 11 == 0) r2 = 64'd1;
                xa = r1[W-1:0]; yb = r2[W-1:0]; sb = 1'($urandom); ci = 1'($urandom); st = 1'b1;
                model(W, longint'(xa), longint'(yb), sb, ci, es, eco, eov);
                @(posedge clk); #1;
                st = 1'b0; xa = ~xa; yb = yb ^ r1[W-1:0]; sb = ~sb; ci = ~ci;
                lat = 0;
                while (!dn && lat < W + 4) begin @(posedge clk); #1; lat++; end
                chk($sformatf("sw%0d_lat", g), lat, W / C);
                chk($sformatf("sw%0d_s", g), sm, es);
                chk($sformatf("sw%0d_cout", g), co, eco);
                chk($sformatf("sw%0d_ovf", g), ov, eov);
            end
            fin = 1'b1;
        end
    end
    initial begin
        int lat;
        bit seen;
        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; x = '0; y = '0;
        #2;
        chk("rst_state", {busy, done, cout, ovf}, 4'b0000);
        chk("rst_s", s, 16'h0000);
        @(posedge clk); #1 rst = 1'b0;
        op("basic", 16'h1234, 16'h0FCD, 1'b0, 1'b0);
        chk("basic_const", s, 16'h2201);
        @(posedge clk); #1;
        chk("done_pulse", {busy, done}, 2'b00);
        op("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        chk("wrap_const", {cout, ovf, s}, {2'b10, 16'h0000});
        op("ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        chk("ovf_const", {cout, ovf, s}, {2'b01, 16'h8000});
        op("cin", 16'h0000, 16'h0000, 1'b0, 1'b1);
        chk("cin_const", s, 16'h0001);
        op("sub", 16'h0005, 16'h0007, 1'b1, 1'b0);
        chk("sub_const", {cout, ovf, s}, {2'b00, 16'hFFFE});
        op("subcin", 16'h0005, 16'h0007, 1'b1, 1'b1);
        chk("subcin_const", s, 16'hFFFE);
        start = 1'b1; x = 16'h1111; y = 16'h2222; sub = 1'b0; cin = 1'b0;
        @(posedge clk); #1;
        lat = 0;
        while (!done && lat < 20) begin
            start = 1'b1; x = 16'($urandom); y = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
            @(posedge clk); #1; lat++;
        end
        start = 1'b0;
        chk("ign_lat", lat, 4);
        chk("ign_s", s, 16'h3333);
        @(posedge clk); #1;
        chk("ign_idle", {busy, done}, 2'b00);
        op("b2b_a", 16'h0100, 16'h0023, 1'b0, 1'b0);
        start = 1'b1; x = 16'h4000; y = 16'h0001; sub = 1'b1; cin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("b2b_gap", lat, 5);
        chk("b2b_s", s, 16'h3FFF);
        op("vsub", 16'h8000, 16'h0001, 1'b1, 1'b0);
        chk("vsub_const", {cout, ovf, s}, {2'b11, 16'h7FFF});
        start = 1'b1; x = 16'h0F0F; y = 16'h7777; sub = 1'b0; cin = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_state", {busy, done, cout, ovf}, 4'b0000);
        chk("mid_rst_s", s, 16'h0000);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin @(posedge clk); #1; seen |= done; end
        chk("mid_rst_nodone", seen, 0);
        op("post_rst", 16'hABCD, 16'h1234, 1'b0, 1'b1);
        chk("post_rst_const", s, 16'hBE02);
        for (int t = 0; t < 40000 && !(sw[0].fin && sw[1].fin && sw[2].fin && sw[3].fin); t++) @(posedge clk);
        chk("sweep_finished", {sw[3].fin, sw[2].fin, sw[1].fin, sw[0].fin}, 4'hF);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/multi_cycle_adder.md
# multi_cycle_adder

Parametrised, sequential successor to the 4-bit ripple adder. It adds or subtracts two WIDTH-bit operands one CHUNK-bit slice per clock, LSB slice first, using a start/done handshake. Unlike the ripple adder, it honours carry-in and provides subtract mode and a signed-overflow flag. It sits in datapaths where a wide single-cycle carry chain would not close timing, trading latency for area and clock rate.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH.
- Derived: NCHUNK = WIDTH/CHUNK.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- sub  in  1  0: s = x + y + cin; 1: s = x − y (cin ignored).
- cin  in  1  carry-in for add mode.
- x  in  WIDTH  operand A.
- y  in  WIDTH  operand B.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when s/cout/ovf become valid.
- s  out  WIDTH  result; held until the next result is written.
- cout  out  1  carry out of the MSB. In subtract mode, 1 means no borrow.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE / DONE, start=1:** latch x into A. Latch y into B, or ~y when sub=1. Set carry register to sub ? 1 : cin. Clear slice counter k to 0. Go to RUN.
- **IDLE / DONE, start=0:** DONE goes to IDLE; IDLE stays in IDLE.
- **RUN:** each edge adds slice k of A and B plus the carry register. Write the CHUNK-bit sum into slice k of the internal sum register, update the carry register, then increment k.
- **Last slice (k = NCHUNK−1):** copy the internal sum to s, set cout from the final carry, and set ovf = carry into bit WIDTH−1 XOR final carry. Go to DONE.
- **Start while busy:** start while busy=1 is ignored. No queueing, and in-flight operands are unaffected.
- **Input stability:** x, y, sub and cin are only sampled on the accepting edge; they may change freely afterwards.
- **Arithmetic:** all modulo 2^WIDTH, with no width extension. Subtraction is two's complement (x + ~y + 1).
- **Output stability:** s, cout and ovf change only on the final RUN edge. They never show partial sums.

## Timing
- **Reset values:** state=IDLE, k=0, busy=0, done=0, s=0, cout=0, ovf=0, and internal registers 0.
- **Reset mid-RUN:** rst asserted during RUN aborts the operation immediately (asynchronous). done does not pulse, and outputs return to their reset values.
- **Accept edge:** start is accepted on edge E0. busy=1 from after E0 through the cycle of edge E_NCHUNK.
- **Result edge:** on E_NCHUNK, results are registered and the state goes to DONE.
- **done timing:** done=1 for exactly the one cycle after E_NCHUNK. Latency from the accepting edge to done high is NCHUNK cycles.
- **Back-to-back:** start=1 during the DONE cycle is accepted. Back-to-back throughput is one result per NCHUNK+1 cycles.
- **busy:** combinational from state (busy = state==RUN). done is likewise decoded from state==DONE, so both are registered-state-driven with no input-to-output combinational path.
- **CHUNK=WIDTH:** NCHUNK=1, giving a single RUN cycle and a 1-cycle latency.

## Structure
- **Package adder_pkg:** state typedef (IDLE, RUN, DONE) and the op encoding constants OP_ADD=0, OP_SUB=1.
- **Sub-module chunk_add:** combinational CHUNK-bit adder, generalising the 1-bit full adder.
  - Inputs: a, b, ci. Outputs: sum, co, and c_msb (carry into its top bit, used for ovf).
  - Instantiated once and shared across slices through the slice counter mux.
- **Elaboration checks:** parameter assertions for WIDTH % CHUNK == 0 and CHUNK ≥ 1.

## Test plan
(WIDTH=16, CHUNK=4 unless noted.)
- **Basic add:** x=0x1234, y=0x0FCD, sub=0, cin=0, pulse start → done 4 cycles later; s=0x2201, cout=0, ovf=0.
- **Carry and overflow:**
  - 0xFFFF+0x0001 → s=0x0000, cout=1, ovf=0.
  - 0x7FFF+0x0001 → s=0x8000, cout=0, ovf=1.
  - x=0, y=0, cin=1 → s=0x0001.
- **Subtract:**
  - 0x0005−0x0007 → s=0xFFFE, cout=0, ovf=0.
  - 0x8000−0x0001 → s=0x7FFF, ovf=1.
  - cin=1 has no effect in subtract mode.
- **Handshake:**
  - start re-asserted in each RUN cycle with different operands → ignored, and the first result is unchanged.
  - start in the DONE cycle → second result 5 cycles after the first.
- **Reset mid-operation:** assert rst during the 2nd RUN cycle → busy, done, s, cout and ovf go to 0 immediately; no done pulse; the next start works normally.
- **Parameter sweep:** CHUNK ∈ {1, 4, 16} with WIDTH=16, plus WIDTH=32/CHUNK=8, with 1000 random ops each → every result matches the reference model (x ± y + cin) mod 2^WIDTH, and the latency equals NCHUNK.
